// File: rtl/exp_interval_event_gen.sv
// Poisson event generator: consumes exponential samples as inter-arrival gaps,
// counts each gap down and emits a one-cycle event pulse with observability counters.
module exp_interval_event_gen #(
  parameter int unsigned X_WID   = 16,
  parameter int unsigned SHIFT   = 0,
  parameter int unsigned EVT_WID = 16,
  parameter int unsigned STV_WID = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clear_i,
  input  logic [X_WID-1:0]   sample_i,
  input  logic               sample_valid_i,
  output logic               sample_ready_o,
  output logic               event_o,
  output logic               busy_o,
  output logic [X_WID-1:0]   remain_o,
  output logic [EVT_WID-1:0] event_count_o,
  output logic [STV_WID-1:0] starve_count_o
);

  typedef enum logic [1:0] {IDLE, FETCH, COUNT, FIRE} state_t;

  state_t             state, state_nxt;
  logic [X_WID-1:0]   remain, remain_nxt;
  logic [X_WID-1:0]   gap_raw;
  logic [EVT_WID-1:0] evt_cnt, evt_nxt;
  logic [STV_WID-1:0] stv_cnt, stv_nxt;

  assign gap_raw = sample_i >> SHIFT;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      remain  <= '0;
      evt_cnt <= '0;
      stv_cnt <= '0;
    end else begin
      state   <= state_nxt;
      remain  <= remain_nxt;
      evt_cnt <= evt_nxt;
      stv_cnt <= stv_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    evt_nxt    = evt_cnt;
    stv_nxt    = stv_cnt;
    case (state)
      IDLE: begin
        if (en_i) state_nxt = FETCH;
      end
      FETCH: begin
        if (sample_valid_i) begin
          // remain holds G-1 on entry to COUNT so FIRE lands exactly G cycles after the handshake
          if (gap_raw > X_WID'(1)) begin
            state_nxt  = COUNT;
            remain_nxt = gap_raw - X_WID'(1);
          end else begin
            state_nxt = FIRE;
          end
        end else if (!en_i) begin
          state_nxt = IDLE;
        end else if (stv_cnt != '1) begin
          stv_nxt = stv_cnt + STV_WID'(1);
        end
      end
      COUNT: begin
        if (remain <= X_WID'(1)) begin
          remain_nxt = '0;
          state_nxt  = FIRE;
        end else begin
          remain_nxt = remain - X_WID'(1);
        end
      end
      FIRE: begin
        if (evt_cnt != '1) evt_nxt = evt_cnt + EVT_WID'(1);
        state_nxt = en_i ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear_i) begin
      state_nxt  = IDLE;
      remain_nxt = '0;
      evt_nxt    = '0;
      stv_nxt    = '0;
    end
  end

  assign sample_ready_o = (state == FETCH);
  assign event_o        = (state == FIRE);
  assign busy_o         = (state != IDLE);
  assign remain_o       = remain;
  assign event_count_o  = evt_cnt;
  assign starve_count_o = stv_cnt;

endmodule

// File: tb/tb_exp_interval_event_gen.sv
// Directed bench for exp_interval_event_gen: three instances share stimulus
// (SHIFT=0, SHIFT=4, EVT_WID=4); each section resets all of them first.
module tb_exp_interval_event_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clear;
  logic        valid;
  logic [15:0] sample;

  logic        a_ready, a_event, a_busy;
  logic [15:0] a_remain, a_evt;
  logic [7:0]  a_stv;
  logic        s_ready, s_event, s_busy;
  logic [15:0] s_remain, s_evt;
  logic [7:0]  s_stv;
  logic        e_ready, e_event, e_busy;
  logic [15:0] e_remain;
  logic [3:0]  e_evt;
  logic [7:0]  e_stv;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exp_interval_event_gen #(.X_WID(16), .SHIFT(0), .EVT_WID(16), .STV_WID(8)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear), .sample_i(sample),
    .sample_valid_i(valid), .sample_ready_o(a_ready), .event_o(a_event), .busy_o(a_busy),
    .remain_o(a_remain), .event_count_o(a_evt), .starve_count_o(a_stv));

  exp_interval_event_gen #(.X_WID(16), .SHIFT(4), .EVT_WID(16), .STV_WID(8)) dut_s (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear), .sample_i(sample),
    .sample_valid_i(valid), .sample_ready_o(s_ready), .event_o(s_event), .busy_o(s_busy),
    .remain_o(s_remain), .event_count_o(s_evt), .starve_count_o(s_stv));

  exp_interval_event_gen #(.X_WID(16), .SHIFT(0), .EVT_WID(4), .STV_WID(8)) dut_e (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clear), .sample_i(sample),
    .sample_valid_i(valid), .sample_ready_o(e_ready), .event_o(e_event), .busy_o(e_busy),
    .remain_o(e_remain), .event_count_o(e_evt), .starve_count_o(e_stv));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; en = 1'b0; clear = 1'b0; valid = 1'b0; sample = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; valid = 1'b0; sample = '0;
    #1;
    chk("rst_ready",  32'(a_ready),  32'd0);
    chk("rst_event",  32'(a_event),  32'd0);
    chk("rst_busy",   32'(a_busy),   32'd0);
    chk("rst_remain", 32'(a_remain), 32'd0);
    chk("rst_evt",    32'(a_evt),    32'd0);
    chk("rst_stv",    32'(a_stv),    32'd0);

    // gap of 5: countdown 4..1 then a single event
    do_reset();
    en = 1'b1;
    step();
    chk("t1_fetch_ready", 32'(a_ready), 32'd1);
    chk("t1_fetch_busy",  32'(a_busy),  32'd1);
    valid = 1'b1; sample = 16'd5;
    step();
    valid = 1'b0;
    chk("t1_h1_remain", 32'(a_remain), 32'd4);
    chk("t1_h1_ready",  32'(a_ready),  32'd0);
    step(); chk("t1_h2_remain", 32'(a_remain), 32'd3);
    step(); chk("t1_h3_remain", 32'(a_remain), 32'd2);
    step(); chk("t1_h4_remain", 32'(a_remain), 32'd1);
    chk("t1_h4_event", 32'(a_event), 32'd0);
    step();
    chk("t1_h5_event",  32'(a_event),  32'd1);
    chk("t1_h5_remain", 32'(a_remain), 32'd0);
    step();
    chk("t1_h6_event", 32'(a_event), 32'd0);
    chk("t1_h6_count", 32'(a_evt),   32'd1);
    chk("t1_h6_ready", 32'(a_ready), 32'd1);

    // samples 0 then 1: both G=1, events two cycles apart
    do_reset();
    en = 1'b1;
    step();
    valid = 1'b1; sample = 16'd0;
    step();
    chk("t2_ev0", 32'(a_event), 32'd1);
    sample = 16'd1;
    step();
    chk("t2_gap_event", 32'(a_event), 32'd0);
    chk("t2_gap_ready", 32'(a_ready), 32'd1);
    step();
    chk("t2_ev1", 32'(a_event), 32'd1);
    valid = 1'b0;
    step();
    chk("t2_count", 32'(a_evt), 32'd2);

    // SHIFT=4: 0x0040 -> G=4, 0x000F -> G=1
    do_reset();
    en = 1'b1;
    step();
    valid = 1'b1; sample = 16'h0040;
    step();
    valid = 1'b0;
    chk("t3_h1_remain", 32'(s_remain), 32'd3);
    step(); chk("t3_h2_remain", 32'(s_remain), 32'd2);
    step(); chk("t3_h3_event",  32'(s_event),  32'd0);
    step(); chk("t3_h4_event",  32'(s_event),  32'd1);
    step();
    chk("t3_fetch_ready", 32'(s_ready), 32'd1);
    valid = 1'b1; sample = 16'h000F;
    step();
    valid = 1'b0;
    chk("t3_g1_event", 32'(s_event), 32'd1);

    // en dropped mid-count: pending gap of 8 still completes, then IDLE
    do_reset();
    en = 1'b1;
    step();
    valid = 1'b1; sample = 16'd8;
    step();
    valid = 1'b0;
    chk("t4_h1_remain", 32'(a_remain), 32'd7);
    step();
    en = 1'b0;
    chk("t4_h2_remain", 32'(a_remain), 32'd6);
    for (int i = 3; i <= 7; i++) begin
      step();
      chk("t4_count_event", 32'(a_event), 32'd0);
    end
    chk("t4_h7_remain", 32'(a_remain), 32'd1);
    step();
    chk("t4_h8_event", 32'(a_event), 32'd1);
    step();
    chk("t4_idle_ready", 32'(a_ready), 32'd0);
    chk("t4_idle_busy",  32'(a_busy),  32'd0);
    step();
    chk("t4_idle_ready2", 32'(a_ready), 32'd0);

    // starvation counter saturates at 255
    do_reset();
    en = 1'b1;
    step();
    chk("t5_stv0", 32'(a_stv), 32'd0);
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 100) chk("t5_stv100", 32'(a_stv), 32'd100);
      if (k == 255) chk("t5_stv255", 32'(a_stv), 32'd255);
    end
    chk("t5_stv_sat", 32'(a_stv), 32'd255);
    valid = 1'b1; sample = 16'd3;
    step();
    valid = 1'b0;
    chk("t5_hs_remain", 32'(a_remain), 32'd2);
    chk("t5_hs_ready",  32'(a_ready),  32'd0);

    // EVT_WID=4: event counter holds at 15
    do_reset();
    en = 1'b1; valid = 1'b1; sample = 16'd0;
    for (int k = 1; k <= 45; k++) begin
      step();
      if (k == 29) chk("t6_count14", 32'(e_evt), 32'd14);
      if (k == 31) chk("t6_count15", 32'(e_evt), 32'd15);
    end
    valid = 1'b0;
    chk("t6_count_sat", 32'(e_evt), 32'd15);

    // asynchronous reset mid-count aborts the pending event
    do_reset();
    en = 1'b1;
    step();
    valid = 1'b1; sample = 16'd10;
    step();
    valid = 1'b0;
    step();
    chk("t7_pre_remain", 32'(a_remain), 32'd8);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_remain", 32'(a_remain), 32'd0);
    chk("t7_async_busy",   32'(a_busy),   32'd0);
    chk("t7_async_ready",  32'(a_ready),  32'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      chk("t7_no_event", 32'(a_event), 32'd0);
    end

    // clear during FIRE: pulse still visible, then counters zero and IDLE
    do_reset();
    en = 1'b1;
    step();
    valid = 1'b1; sample = 16'd0;
    step();
    valid = 1'b0;
    step();
    step();
    chk("t8_pre_stv", 32'(a_stv), 32'd1);
    valid = 1'b1; sample = 16'd2;
    step();
    valid = 1'b0;
    chk("t8_remain", 32'(a_remain), 32'd1);
    step();
    clear = 1'b1;
    chk("t8_fire_event", 32'(a_event), 32'd1);
    chk("t8_fire_count", 32'(a_evt),   32'd1);
    step();
    clear = 1'b0;
    chk("t8_clr_evt",   32'(a_evt),   32'd0);
    chk("t8_clr_stv",   32'(a_stv),   32'd0);
    chk("t8_clr_busy",  32'(a_busy),  32'd0);
    chk("t8_clr_event", 32'(a_event), 32'd0);
    step();
    chk("t8_refetch", 32'(a_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
